// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, register-bank constants and the output-register state encoding
// for the operand fetch stage.
package operand_fetch_stage_pkg;
  localparam int DATA_WIDTH = 24;
  localparam int SEL_WIDTH  = 3;
  localparam int NUM_REGS   = 8;
  localparam logic [0:SEL_WIDTH-1] ZERO_REG = 3'd0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ofs_state_e;
endpackage

// File: rtl/operand_fetch_stage_mux.sv
// 8-to-1 word multiplexer used by both register read ports; output is zero when
// disabled.
module Mux_8_1 #(
  parameter int DATA_WIDTH = operand_fetch_stage_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH  = operand_fetch_stage_pkg::SEL_WIDTH
) (
  input  logic [0:DATA_WIDTH-1] d [2**SEL_WIDTH],
  input  logic [0:SEL_WIDTH-1]  sel,
  input  logic                  enb,
  output logic [0:DATA_WIDTH-1] y
);
  always_comb begin
    y = '0;
    if (enb) y = d[sel];
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: 8-entry register bank, two muxed read ports with write-through
// bypass, and a one-entry valid/ready output register.
module operand_fetch_stage #(
  parameter int DATA_WIDTH = operand_fetch_stage_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH  = operand_fetch_stage_pkg::SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:SEL_WIDTH-1]  rs_a,
  input  logic [0:SEL_WIDTH-1]  rs_b,
  input  logic                  wr_enb,
  input  logic [0:SEL_WIDTH-1]  wr_sel,
  input  logic [0:DATA_WIDTH-1] wr_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:DATA_WIDTH-1] opa,
  output logic [0:DATA_WIDTH-1] opb
);
  import operand_fetch_stage_pkg::*;

  localparam int NREGS = 2**SEL_WIDTH;

  // Handshake: a transfer happens on a port in any cycle where its valid and
  // ready are both high; valid never depends on ready from the same side.

  logic [0:DATA_WIDTH-1] regs_q [NREGS];
  logic [0:DATA_WIDTH-1] regs_d [NREGS];
  logic [0:DATA_WIDTH-1] mux_a, mux_b;
  logic [0:DATA_WIDTH-1] byp_a, byp_b;
  logic [0:DATA_WIDTH-1] opa_d, opa_q, opb_d, opb_q;
  ofs_state_e            state_d, state_q;
  logic                  wr_live;
  logic                  accept;

  assign wr_live = wr_enb && (wr_sel != ZERO_REG);

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wr_live) regs_d[wr_sel] = wr_data;
  end

  Mux_8_1 #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_mux_a (
    .d(regs_q), .sel(rs_a), .enb(1'b1), .y(mux_a)
  );

  Mux_8_1 #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_mux_b (
    .d(regs_q), .sel(rs_b), .enb(1'b1), .y(mux_b)
  );

  // wr_live already excludes register 0, so a zero selector never bypasses.
  assign byp_a = (wr_live && (wr_sel == rs_a)) ? wr_data : mux_a;
  assign byp_b = (wr_live && (wr_sel == rs_b)) ? wr_data : mux_b;

  assign in_ready = !flush && ((state_q == EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    if (accept) begin
      opa_d = byp_a;
      opb_d = byp_b;
    end
    if (flush)                          state_d = EMPTY;
    else if (accept)                    state_d = FULL;
    else if (state_q == FULL && out_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      state_q <= EMPTY;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign opa       = opa_q;
  assign opb       = opb_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios then random traffic, checked
// against an array-based register model and an expected-operand queue.
module tb_operand_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:2]  rs_a, rs_b, wr_sel;
  logic        wr_enb;
  logic [0:23] wr_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [0:23] opa, opb;

  int tests_run;
  int tests_failed;

  // reference state
  logic [23:0] m_regs [8];
  logic        m_valid;
  logic [23:0] m_opa, m_opb;
  logic [47:0] exp_q [$];

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_a(rs_a), .rs_b(rs_b), .wr_enb(wr_enb), .wr_sel(wr_sel),
    .wr_data(wr_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opa(opa), .opb(opb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [47:0] act, input logic [47:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_opa   = '0;
    m_opb   = '0;
    exp_q.delete();
  endtask

  function automatic logic [23:0] model_read(input logic [2:0] r, input logic we,
                                             input logic [2:0] ws, input logic [23:0] wd);
    if (r == 3'd0) return 24'h0;
    if (we && ws == r) return wd;
    return m_regs[r];
  endfunction

  task automatic step(input logic iv, input logic [2:0] ra, input logic [2:0] rb,
                      input logic we, input logic [2:0] ws, input logic [23:0] wd,
                      input logic fl, input logic ordy);
    logic        rdy, acc;
    logic [47:0] pair;
    @(negedge clk);
    in_valid = iv; rs_a = ra; rs_b = rb; wr_enb = we; wr_sel = ws;
    wr_data = wd; flush = fl; out_ready = ordy;
    #1;
    rdy = !fl && (!m_valid || ordy);
    acc = iv && rdy;
    check_val("in_ready", {47'd0, in_ready}, {47'd0, rdy});
    if (m_valid && ordy && !fl) begin
      if (exp_q.size() == 0) begin
        check_val("handoff_queue_empty", 48'd1, 48'd0);
      end else begin
        pair = exp_q.pop_front();
        check_val("handoff_pair", {opa, opb}, pair);
      end
    end
    if (fl) exp_q.delete();
    @(posedge clk);
    if (acc) begin
      m_opa = model_read(ra, we, ws, wd);
      m_opb = model_read(rb, we, ws, wd);
      exp_q.push_back({m_opa, m_opb});
    end
    if (fl)                    m_valid = 1'b0;
    else if (acc)              m_valid = 1'b1;
    else if (m_valid && ordy)  m_valid = 1'b0;
    if (we && ws != 3'd0) m_regs[ws] = wd;
    #1;
    check_val("out_valid", {47'd0, out_valid}, {47'd0, m_valid});
    check_val("opa", {24'd0, opa}, {24'd0, m_opa});
    check_val("opb", {24'd0, opb}, {24'd0, m_opb});
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 24'h0, 1'b0, ordy);
  endtask

  initial begin
    logic [23:0] held_a;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0; in_valid = 1'b0; rs_a = '0; rs_b = '0; wr_enb = 1'b0;
    wr_sel = '0; wr_data = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_val("rst_in_ready", {47'd0, in_ready}, 48'd1);
    check_val("rst_out_valid", {47'd0, out_valid}, 48'd0);
    check_val("rst_opa", {24'd0, opa}, 48'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // read after reset: all zero
    step(1'b1, 3'd3, 3'd7, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
    idle(1'b1);

    // write reg1..reg7, then read back
    for (int i = 1; i < 8; i++)
      step(1'b0, 3'd0, 3'd0, 1'b1, 3'(i), {3{8'(i)}}, 1'b0, 1'b1);
    step(1'b1, 3'd5, 3'd2, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
    check_val("readback_opa", {24'd0, opa}, 48'h050505);
    check_val("readback_opb", {24'd0, opb}, 48'h020202);

    // bypass and register 0
    step(1'b1, 3'd4, 3'd1, 1'b1, 3'd4, 24'hABCDEF, 1'b0, 1'b1);
    check_val("bypass_opa", {24'd0, opa}, 48'hABCDEF);
    step(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 24'h123456, 1'b0, 1'b1);
    step(1'b1, 3'd6, 3'd0, 1'b1, 3'd0, 24'h654321, 1'b0, 1'b1);
    check_val("r0_opb", {24'd0, opb}, 48'h0);
    idle(1'b1);

    // backpressure: fill, stall 5 cycles while rewriting the source register
    step(1'b1, 3'd3, 3'd5, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0);
    held_a = m_opa;
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'd7, 3'd6, 1'b1, 3'd3, 24'(32'h00A000 + i), 1'b0, 1'b0);
    check_val("stall_opa_held", {24'd0, opa}, {24'd0, held_a});
    step(1'b1, 3'd3, 3'd7, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
    check_val("post_stall_opa", {24'd0, opa}, 48'h00A004);
    idle(1'b1);

    // flush beats a valid request
    step(1'b1, 3'd1, 3'd2, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 24'h0, 1'b1, 1'b1);
    idle(1'b1);

    // asynchronous reset in the middle of a stall
    step(1'b1, 3'd5, 3'd6, 1'b0, 3'd0, 24'h0, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midstall_rst_valid", {47'd0, out_valid}, 48'd0);
    check_val("midstall_rst_opa", {24'd0, opa}, 48'd0);
    check_val("midstall_rst_in_ready", {47'd0, in_ready}, 48'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd5, 3'd6, 1'b0, 3'd0, 24'h0, 1'b0, 1'b1);
    idle(1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           24'($urandom),
           1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Operand fetch stage for the 24-bit datapath: an 8 x 24-bit register bank whose two read ports are selected through the existing 8-to-1 multiplexer, with write-through bypass and a one-entry output pipeline register using a valid/ready handshake. It sits directly upstream of the execute stage. Its read side is the producer that drives the multiplexer select lines and captures the multiplexer output.

## Interface
Parameters:
- DATA_WIDTH, 24, operand / register width; bits numbered [0:DATA_WIDTH-1], bit 0 = MSB
- SEL_WIDTH, 3, register selector width; 2**SEL_WIDTH = 8 registers

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents rs_a/rs_b
- in_ready  out  1  stage can accept this cycle
- rs_a  in  [0:2]  read selector, operand A
- rs_b  in  [0:2]  read selector, operand B
- wr_enb  in  1  register write enable (write-back port)
- wr_sel  in  [0:2]  write selector
- wr_data  in  [0:23]  write data
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  opa/opb hold a valid operand pair
- out_ready  in  1  downstream accepts operands
- opa  out  [0:23]  registered operand A
- opb  out  [0:23]  registered operand B

## Operation
- Register 0 reads as 24'h000000; writes to it are ignored. Registers 1-7 are general.
- Write: when wr_enb=1 and wr_sel!=0, reg[wr_sel] <= wr_data at the clock edge. The write is independent of the handshake, stall, and flush.
- Read path: each port goes through one mux instance with sel=rs_x and enb=1.
- Bypass: if wr_enb=1, wr_sel==rs_x, and rs_x!=0, the captured value is wr_data, not the mux output.
- in_ready = !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, opa/opb <= bypassed read values and out_valid <= 1.
- If out_valid && out_ready and there is no accept, out_valid <= 0 and opa/opb hold their values.
- Stall: while out_valid && !out_ready, opa/opb hold. A write to a source register during the stall does not refresh the held operands; hazard tracking is the issuer's responsibility.
- Flush: out_valid <= 0 and no accept occurs that cycle. opa/opb are not cleared. Flush has priority over accept and hand-off.
- Output states are EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY→FULL on accept
  - FULL→FULL on out_ready with accept, or while stalled
  - FULL→EMPTY on out_ready without accept
  - any state→EMPTY on flush

## Timing
- Reset (asynchronous, rst_n=0) clears:
  - all registers to 0
  - out_valid to 0
  - opa/opb to 24'h000000
- in_ready is combinational and equals 1 during and after reset (flush=0).
- Latency: accept at edge N gives out_valid=1 with data visible after edge N.
- Throughput: one operand pair per cycle while out_ready=1.
- A write at edge N is visible through the mux (no bypass needed) for reads captured at edge N+1.
- Simultaneous write and read of the same register: the new data is returned (bypass).
- Reset asserted mid-stall: the held pair is lost, out_valid=0 immediately, and nothing is replayed.

## Structure
- Shared package/include holds:
  - DATA_WIDTH=24
  - SEL_WIDTH=3
  - NUM_REGS=8
  - ZERO_REG=3'd0
  - the EMPTY/FULL state encoding
- Sub-module: two instances of the existing Mux_8_1 (read ports A and B), with enb tied to 1.
- Register bank, bypass compare, and output register live in this module.

## Test plan
- Reset then read: rst_n pulse, then rs_a=3, rs_b=7 → after 1 cycle out_valid=1, opa=opb=24'h000000.
- Write/readback: write reg1..reg7 = 24'h010101..24'h070707, then rs_a=5, rs_b=2 → opa=24'h050505, opb=24'h020202.
- Bypass and R0:
  - wr_sel=4, wr_data=24'hABCDEF in the same cycle as rs_a=4 → opa=24'hABCDEF.
  - A write to reg 0 followed by rs_b=0 → opb=24'h000000.
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0, opa/opb stable for 5 cycles even while reg[rs_a] is rewritten. Then out_ready=1 → the next pair is accepted, with no loss or duplication.
- Flush and async reset:
  - flush=1 with in_valid=1 → out_valid=0 next cycle and the request is not captured.
  - rst_n=0 mid-stall → out_valid=0 and opa=0 before the next clock edge.
